// File: rtl/pipe_front_regs_pkg.sv
// Shared types and constants for the front-end pipeline register bank.
package pipe_front_regs_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef logic [XLEN-1:0] pc_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    pc_t             pc;
    pc_t             pc_plus4;
    logic            valid;
  } dc_reg_t;

  typedef struct packed {
    pc_t  pc;
    pc_t  pc_plus4;
    logic valid;
  } ex_pc_reg_t;

endpackage

// File: rtl/pipe_front_regs_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_front_regs.sv
// Fetch PC, fetch->decode and decode->execute registers with stall/flush/redirect
// handling, plus saturating stall and redirect counters.
module pipe_front_regs
  import pipe_front_regs_pkg::NOP_INSTR;
  import pipe_front_regs_pkg::ILEN;
  import pipe_front_regs_pkg::dc_reg_t;
  import pipe_front_regs_pkg::ex_pc_reg_t;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_ft_i,
  input  logic             stall_dc_i,
  input  logic             flush_dc_i,
  input  logic             flush_ex_i,
  input  logic             pc_src_ex_i,
  input  logic [XLEN-1:0]  pc_target_ex_i,
  input  logic [ILEN-1:0]  instr_ft_i,
  output logic [XLEN-1:0]  pc_ft_o,
  output logic [ILEN-1:0]  instr_dc_o,
  output logic [XLEN-1:0]  pc_dc_o,
  output logic [XLEN-1:0]  pc_plus4_dc_o,
  output logic             valid_dc_o,
  output logic [XLEN-1:0]  pc_ex_o,
  output logic [XLEN-1:0]  pc_plus4_ex_o,
  output logic             valid_ex_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  // The register payload structs are sized by the package XLEN.
  if (XLEN != pipe_front_regs_pkg::XLEN) begin : g_bad_xlen
    $error("pipe_front_regs: XLEN must match pipe_front_regs_pkg::XLEN");
  end

  localparam dc_reg_t    DC_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
  localparam ex_pc_reg_t EX_BUBBLE = '{pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [XLEN-1:0] pc_ft;
  dc_reg_t         dc_reg;
  ex_pc_reg_t      ex_reg;

  // Fetch PC: redirect beats stall; sequential advance wraps modulo 2^XLEN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_ft <= RESET_PC;
    end else if (pc_src_ex_i) begin
      pc_ft <= pc_target_ex_i;
    end else if (!stall_ft_i) begin
      pc_ft <= pc_ft + XLEN'(4);
    end
  end

  // Fetch->decode: flush beats stall; pc_plus4 is stored, not recomputed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dc_reg <= DC_BUBBLE;
    end else if (flush_dc_i) begin
      dc_reg <= DC_BUBBLE;
    end else if (!stall_dc_i) begin
      dc_reg <= '{instr: instr_ft_i, pc: pc_ft, pc_plus4: pc_ft + XLEN'(4), valid: 1'b1};
    end
  end

  // Decode->execute never holds; hazards insert bubbles here instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_reg <= EX_BUBBLE;
    end else if (flush_ex_i) begin
      ex_reg <= EX_BUBBLE;
    end else begin
      ex_reg <= '{pc: dc_reg.pc, pc_plus4: dc_reg.pc_plus4, valid: dc_reg.valid};
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_dc_i & ~flush_dc_i),
    .cnt_o  (stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (pc_src_ex_i),
    .cnt_o  (redirect_cnt_o)
  );

  assign pc_ft_o       = pc_ft;
  assign instr_dc_o    = dc_reg.instr;
  assign pc_dc_o       = dc_reg.pc;
  assign pc_plus4_dc_o = dc_reg.pc_plus4;
  assign valid_dc_o    = dc_reg.valid;
  assign pc_ex_o       = ex_reg.pc;
  assign pc_plus4_ex_o = ex_reg.pc_plus4;
  assign valid_ex_o    = ex_reg.valid;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: table of hazard vectors with a scoreboard queue,
// plus PC wrap, counter saturation and mid-cycle reset sequences.
module tb_pipe_front_regs;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        stall_ft = 1'b0, stall_dc = 1'b0, flush_dc = 1'b0, flush_ex = 1'b0, pc_src = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] instr_ft, pc_ft, instr_dc, pc_dc, pc_plus4_dc, pc_ex, pc_plus4_ex;
  logic        valid_dc, valid_ex;
  logic [31:0] stall_cycles, redirect_cnt;

  // Instruction memory stand-in: a distinct word per PC
  function automatic logic [31:0] imem(input logic [31:0] pc);
    return (pc == 32'h0) ? 32'h0050_0093 : (32'hA000_0000 ^ pc);
  endfunction
  assign instr_ft = imem(pc_ft);

  pipe_front_regs dut (
    .clk_i(clk), .rst_ni(rst_n),
    .stall_ft_i(stall_ft), .stall_dc_i(stall_dc), .flush_dc_i(flush_dc), .flush_ex_i(flush_ex),
    .pc_src_ex_i(pc_src), .pc_target_ex_i(target), .instr_ft_i(instr_ft),
    .pc_ft_o(pc_ft), .instr_dc_o(instr_dc), .pc_dc_o(pc_dc), .pc_plus4_dc_o(pc_plus4_dc),
    .valid_dc_o(valid_dc), .pc_ex_o(pc_ex), .pc_plus4_ex_o(pc_plus4_ex), .valid_ex_o(valid_ex),
    .stall_cycles_o(stall_cycles), .redirect_cnt_o(redirect_cnt)
  );

  // Wrap instance: reset PC just below the top of the address space
  logic [31:0] w_pc_ft, w_instr_dc, w_pc_dc, w_pc4_dc, w_pc_ex, w_pc4_ex, w_scnt, w_rcnt;
  logic        w_vdc, w_vex;
  pipe_front_regs #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .stall_ft_i(1'b0), .stall_dc_i(1'b0), .flush_dc_i(1'b0), .flush_ex_i(1'b0),
    .pc_src_ex_i(1'b0), .pc_target_ex_i(32'h0), .instr_ft_i(32'h0),
    .pc_ft_o(w_pc_ft), .instr_dc_o(w_instr_dc), .pc_dc_o(w_pc_dc), .pc_plus4_dc_o(w_pc4_dc),
    .valid_dc_o(w_vdc), .pc_ex_o(w_pc_ex), .pc_plus4_ex_o(w_pc4_ex), .valid_ex_o(w_vex),
    .stall_cycles_o(w_scnt), .redirect_cnt_o(w_rcnt)
  );

  // Saturation instance: 4-bit counters, decode stall held
  logic        s_stall_dc = 1'b0;
  logic [31:0] s_pc_ft, s_instr_dc, s_pc_dc, s_pc4_dc, s_pc_ex, s_pc4_ex;
  logic        s_vdc, s_vex;
  logic [3:0]  s_scnt, s_rcnt;
  pipe_front_regs #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .stall_ft_i(1'b0), .stall_dc_i(s_stall_dc), .flush_dc_i(1'b0), .flush_ex_i(1'b0),
    .pc_src_ex_i(1'b0), .pc_target_ex_i(32'h0), .instr_ft_i(32'h0),
    .pc_ft_o(s_pc_ft), .instr_dc_o(s_instr_dc), .pc_dc_o(s_pc_dc), .pc_plus4_dc_o(s_pc4_dc),
    .valid_dc_o(s_vdc), .pc_ex_o(s_pc_ex), .pc_plus4_ex_o(s_pc4_ex), .valid_ex_o(s_vex),
    .stall_cycles_o(s_scnt), .redirect_cnt_o(s_rcnt)
  );

  typedef struct {
    logic [31:0] pc_ft, pc_dc, pc_ex, scnt, rcnt;
    logic        vdc, vex;
  } exp_t;

  typedef struct {
    logic        sft, sdc, fdc, fex, src;
    logic [31:0] tgt;
    exp_t        e;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sft, input logic sdc, input logic fdc, input logic fex,
                              input logic src, input logic [31:0] tgt,
                              input logic [31:0] e_pc_ft, input logic [31:0] e_pc_dc, input logic e_vdc,
                              input logic [31:0] e_pc_ex, input logic e_vex,
                              input logic [31:0] e_scnt, input logic [31:0] e_rcnt);
    vec_t v;
    v.sft = sft; v.sdc = sdc; v.fdc = fdc; v.fex = fex; v.src = src; v.tgt = tgt;
    v.e.pc_ft = e_pc_ft; v.e.pc_dc = e_pc_dc; v.e.vdc = e_vdc;
    v.e.pc_ex = e_pc_ex; v.e.vex = e_vex; v.e.scnt = e_scnt; v.e.rcnt = e_rcnt;
    return v;
  endfunction

  task automatic check_main(input string tag, input exp_t e);
    check({tag, " pc_ft"}, pc_ft, e.pc_ft);
    check({tag, " pc_dc"}, pc_dc, e.pc_dc);
    check({tag, " valid_dc"}, 32'(valid_dc), 32'(e.vdc));
    check({tag, " instr_dc"}, instr_dc, e.vdc ? imem(e.pc_dc) : NOP);
    check({tag, " pc_plus4_dc"}, pc_plus4_dc, e.vdc ? e.pc_dc + 32'd4 : 32'h0);
    check({tag, " pc_ex"}, pc_ex, e.pc_ex);
    check({tag, " valid_ex"}, 32'(valid_ex), 32'(e.vex));
    check({tag, " pc_plus4_ex"}, pc_plus4_ex, e.vex ? e.pc_ex + 32'd4 : 32'h0);
    check({tag, " stall_cycles"}, stall_cycles, e.scnt);
    check({tag, " redirect_cnt"}, redirect_cnt, e.rcnt);
  endtask

  vec_t vecs[14];
  exp_t rst_e;
  exp_t got;

  initial begin
    //            sft sdc fdc fex src target          pc_ft         pc_dc         vdc pc_ex         vex scnt rcnt
    vecs[0]  = mk(0,  0,  0,  0,  0,  32'h0,          32'h4,        32'h0,        1,  32'h0,        0,  0,   0);
    vecs[1]  = mk(0,  0,  0,  0,  0,  32'h0,          32'h8,        32'h4,        1,  32'h0,        1,  0,   0);
    vecs[2]  = mk(1,  1,  0,  1,  0,  32'h0,          32'h8,        32'h4,        1,  32'h0,        0,  1,   0);
    vecs[3]  = mk(0,  0,  0,  0,  0,  32'h0,          32'hC,        32'h8,        1,  32'h4,        1,  1,   0);
    vecs[4]  = mk(0,  0,  1,  1,  1,  32'h40,         32'h40,       32'h0,        0,  32'h0,        0,  1,   1);
    vecs[5]  = mk(0,  0,  0,  0,  0,  32'h0,          32'h44,       32'h40,       1,  32'h0,        0,  1,   1);
    vecs[6]  = mk(1,  1,  1,  0,  1,  32'h80,         32'h80,       32'h0,        0,  32'h40,       1,  1,   2);
    vecs[7]  = mk(0,  0,  0,  0,  0,  32'h0,          32'h84,       32'h80,       1,  32'h0,        0,  1,   2);
    vecs[8]  = mk(0,  1,  0,  0,  0,  32'h0,          32'h88,       32'h80,       1,  32'h80,       1,  2,   2);
    vecs[9]  = mk(1,  0,  0,  0,  0,  32'h0,          32'h88,       32'h88,       1,  32'h80,       1,  2,   2);
    vecs[10] = mk(0,  0,  0,  1,  0,  32'h0,          32'h8C,       32'h88,       1,  32'h0,        0,  2,   2);
    vecs[11] = mk(0,  0,  0,  0,  1,  32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h8C,      1,  32'h88,       1,  2,   3);
    vecs[12] = mk(0,  0,  0,  0,  0,  32'h0,          32'h0,        32'hFFFF_FFFC, 1, 32'h8C,       1,  2,   3);
    vecs[13] = mk(0,  0,  0,  0,  0,  32'h0,          32'h4,        32'h0,        1,  32'hFFFF_FFFC, 1, 2,   3);
    rst_e = '{pc_ft: 32'h0, pc_dc: 32'h0, pc_ex: 32'h0, scnt: 32'h0, rcnt: 32'h0, vdc: 1'b0, vex: 1'b0};

    // Reset and release between edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_stall_dc = 1'b1;
    #1;
    check_main("reset", rst_e);
    check("reset wrap pc_ft", w_pc_ft, 32'hFFFF_FFFC);
    check("reset sat cnt", 32'(s_scnt), 32'h0);

    // Table-driven run through the scoreboard
    for (int i = 0; i < 14; i++) begin
      stall_ft = vecs[i].sft; stall_dc = vecs[i].sdc; flush_dc = vecs[i].fdc;
      flush_ex = vecs[i].fex; pc_src = vecs[i].src; target = vecs[i].tgt;
      sb.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check_main($sformatf("vec%0d", i), got);
      if (i == 0) check("wrap pc_ft", w_pc_ft, 32'h0);
      if (i == 1) check("wrap pc_ft next", w_pc_ft, 32'h4);
    end
    stall_ft = 0; stall_dc = 0; flush_dc = 0; flush_ex = 0; pc_src = 0; target = '0;

    // Saturation: 14 stall edges so far, then past the 4-bit limit
    check("sat cnt 14", 32'(s_scnt), 32'hE);
    repeat (6) @(posedge clk);
    #1;
    check("sat cnt stuck", 32'(s_scnt), 32'hF);
    check("sat redirect idle", 32'(s_rcnt), 32'h0);

    // Asynchronous reset mid-cycle, away from any edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async rst", rst_e);
    check("async rst sat cnt", 32'(s_scnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post rst pc_ft", pc_ft, 32'h0);
    @(posedge clk);
    #1;
    check("post rst pc_ft+4", pc_ft, 32'h4);
    check("post rst pc_dc", pc_dc, 32'h0);
    check("post rst instr_dc", instr_dc, 32'h0050_0093);
    check("post rst valid_dc", 32'(valid_dc), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Front-end pipeline register bank for the 5-stage core, consuming the stall/flush controls issued by the hazard unit.
- Holds the fetch PC, the fetch→decode register and the decode→execute PC/valid register.
- Applies stall and flush/bubble semantics to these registers and applies branch/jump redirects.
- Keeps saturating performance counters for stall cycles and redirects.

Parameters:
- XLEN, 32, width of PC and address fields
- RESET_PC, 32'h0000_0000, fetch PC after reset
- CNT_W, 32, width of each performance counter

Ports:
- clk_i  in  1  core clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- stall_ft_i  in  1  hold fetch PC
- stall_dc_i  in  1  hold fetch→decode register
- flush_dc_i  in  1  clear fetch→decode register to bubble
- flush_ex_i  in  1  clear decode→execute register to bubble
- pc_src_ex_i  in  1  redirect fetch to pc_target_ex_i
- pc_target_ex_i  in  XLEN  branch/jump target computed in EX
- instr_ft_i  in  32  instruction read at pc_ft_o, combinational from imem
- pc_ft_o  out  XLEN  current fetch PC
- instr_dc_o  out  32  instruction in decode
- pc_dc_o  out  XLEN  PC of decode instruction
- pc_plus4_dc_o  out  XLEN  pc_dc_o + 4
- valid_dc_o  out  1  decode slot holds a real instruction
- pc_ex_o  out  XLEN  PC of execute instruction
- pc_plus4_ex_o  out  XLEN  pc_ex_o + 4
- valid_ex_o  out  1  execute slot holds a real instruction
- stall_cycles_o  out  CNT_W  cycles with stall_dc_i=1 and flush_dc_i=0
- redirect_cnt_o  out  CNT_W  cycles with pc_src_ex_i=1

Behaviour:
- Reset (async assert, sync release):
  - pc_ft_o=RESET_PC.
  - instr_dc_o=NOP_INSTR (32'h0000_0013, addi x0,x0,0).
  - All other PC fields = 0; both valid bits = 0; both counters = 0.
- Fetch PC, evaluated in priority order each cycle:
  - pc_src_ex_i=1 → pc_target_ex_i. Redirect beats stall_ft_i.
  - else stall_ft_i=1 → hold.
  - else → pc_ft_o+4, modulo 2^XLEN; wraps from all-ones−3 to 0.
- Fetch→decode register, evaluated in priority order each cycle:
  - flush_dc_i=1 → instr=NOP_INSTR, pc=0, valid=0. Flush beats stall.
  - else stall_dc_i=1 → hold all fields.
  - else → capture instr_ft_i and pc_ft_o; valid=1.
  - pc_plus4_dc_o is registered alongside, not recomputed at the output.
- Decode→execute register:
  - flush_ex_i=1 → pc=0, pc_plus4=0, valid=0 (bubble).
  - else → capture pc_dc_o, pc_plus4_dc_o, valid_dc_o.
  - No stall input: EX never holds, and the hazard unit bubbles it instead.
- Load-use stall: stall_ft_i, stall_dc_i and flush_ex_i all high.
  - Result: PC and decode hold one cycle, and a bubble enters EX.
  - The same instruction re-issues next cycle.
- Taken branch: pc_src_ex_i, flush_dc_i and flush_ex_i all high.
  - Both younger slots are bubbled; fetch resumes at the target next cycle.
- Latency: fetch→decode is 1 cycle; decode→execute is 1 cycle.
- Counters:
  - Increment by 1 on the edge when the qualifying condition holds.
  - Saturate at all-ones with no wrap.
  - Reset clears them asynchronously.
- Reset mid-operation: all state returns to reset values immediately, independent of the clock. The first fetch after release is RESET_PC.
- pc_target_ex_i is used unchanged; alignment checking is EX's job.

Decomposition:
- definitions_pkg gains:
  - NOP_INSTR constant.
  - pc_t typedef (logic [XLEN-1:0]).
  - packed struct dc_reg_t {instr, pc, pc_plus4, valid}.
  - packed struct ex_pc_reg_t {pc, pc_plus4, valid}.
- One sub-module, sat_counter (parameter W, inputs clk_i, rst_ni, inc_i, output cnt_o), instantiated twice.

Test Plan:
- Reset → pc_ft_o=0, instr_dc_o=32'h13, valid_dc_o=0, valid_ex_o=0, counters=0. After release with no hazards, pc_ft_o = 0, 4, 8 on successive cycles. instr_ft_i=32'h00500093 at PC 0 → instr_dc_o=32'h00500093, pc_dc_o=0, pc_plus4_dc_o=4 one cycle later.
- Load-use: stall_ft/stall_dc/flush_ex high one cycle while pc_ft_o=8, pc_dc_o=4 → next cycle pc_ft_o=8, pc_dc_o=4, valid_ex_o=0, stall_cycles_o=1. The cycle after, pc_ex_o=4, valid_ex_o=1.
- Taken branch: pc_src_ex_i=1, pc_target_ex_i=32'h40, flush_dc/flush_ex high → pc_ft_o=32'h40, valid_dc_o=0, instr_dc_o=32'h13, valid_ex_o=0, redirect_cnt_o=1.
- Redirect with simultaneous stall_ft_i=1 and pc_src_ex_i=1 (target 32'h80) → pc_ft_o=32'h80. Simultaneous flush_dc_i and stall_dc_i → decode bubble, stall_cycles_o unchanged.
- Wrap/saturation: RESET_PC=32'hFFFF_FFFC → PC goes to 0 after one cycle. CNT_W=4 with stall_dc_i held 20 cycles → stall_cycles_o sticks at 4'hF.
- Assert rst_ni low mid-stream between clock edges → outputs return to reset values before the next edge.
